// File: rtl/keypad_scanner.sv
// Scans a 16-key matrix through an external 4-to-16 decoder, debounces presses
// and releases on the shared sense line, and reports key code with valid/held/release flags.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sense,
  output logic [3:0] scan_idx,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);

  typedef enum logic [1:0] {SCAN, CONFIRM, HELD} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DEB_LAST    = 4'(DEBOUNCE_COUNT - 1);

  state_t     state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic [3:0] deb_q, deb_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;
  logic       rel_q, rel_d;
  logic       strobe;

  assign strobe = en && (settle_q == SETTLE_LAST);

  always_comb begin
    state_d  = state_q;
    deb_d    = deb_q;
    cand_d   = cand_q;
    idx_d    = idx_q;
    code_d   = code_q;
    held_d   = held_q;
    valid_d  = 1'b0;
    rel_d    = 1'b0;
    settle_d = (!en || strobe) ? 8'd0 : settle_q + 8'd1;

    if (strobe) begin
      unique case (state_q)
        SCAN: begin
          if (sense) begin
            cand_d  = idx_q;
            deb_d   = 4'd1;
            state_d = CONFIRM;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        CONFIRM: begin
          if (!sense) begin
            // Bounce: drop the candidate and move past it.
            deb_d   = 4'd0;
            idx_d   = cand_q + 4'd1;
            state_d = SCAN;
          end else if (deb_q == DEB_LAST) begin
            code_d  = cand_q;
            valid_d = 1'b1;
            held_d  = 1'b1;
            deb_d   = 4'd0;
            state_d = HELD;
          end else begin
            deb_d = deb_q + 4'd1;
          end
        end
        HELD: begin
          if (sense) begin
            deb_d = 4'd0;
          end else if (deb_q == DEB_LAST) begin
            // Resume after the released key so other keys get served round-robin.
            rel_d   = 1'b1;
            held_d  = 1'b0;
            deb_d   = 4'd0;
            idx_d   = code_q + 4'd1;
            state_d = SCAN;
          end else begin
            deb_d = deb_q + 4'd1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SCAN;
      settle_q <= 8'd0;
      deb_q    <= 4'd0;
      cand_q   <= 4'd0;
      idx_q    <= 4'd0;
      code_q   <= 4'd0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      deb_q    <= deb_d;
      cand_q   <= cand_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
      rel_q    <= rel_d;
    end
  end

  assign scan_idx    = idx_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign key_release = rel_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed, table-driven bench for keypad_scanner (SETTLE=4, DEB=3).
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;

  logic       clk, rst_n, en, sense;
  logic [3:0] scan_idx, key_code;
  logic       key_valid, key_held, key_release;

  keypad_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_COUNT(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sense(sense),
    .scan_idx(scan_idx), .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held), .key_release(key_release)
  );

  typedef struct {
    logic       s;
    logic [3:0] idx;
    logic [3:0] code;
    logic       v;
    logic       h;
    logic       r;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total    = 0;
  int   cyc;
  int   first_valid_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic s, input logic [3:0] idx, input logic [3:0] code,
                              input logic v, input logic h, input logic r);
    vec_t t;
    t.s = s; t.idx = idx; t.code = code; t.v = v; t.h = h; t.r = r;
    vecs.push_back(t);
  endfunction

  // One full settle window with sense held, checked just after the strobe edge.
  task automatic run_vec(input vec_t t, input int n);
    sense = t.s;
    @(posedge clk); #1;
    chk($sformatf("v%0d_pulse_gap", n), {30'd0, key_valid, key_release}, 32'd0);
    repeat (SETTLE - 1) @(posedge clk);
    #1;
    if (key_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
    chk($sformatf("v%0d_idx", n),  32'(scan_idx), 32'(t.idx));
    chk($sformatf("v%0d_code", n), 32'(key_code), 32'(t.code));
    chk($sformatf("v%0d_flags", n), {29'd0, key_valid, key_held, key_release},
        {29'd0, t.v, t.h, t.r});
  endtask

  initial begin
    logic bad;
    logic saw_rel;
    rst_n = 1'b0; en = 1'b1; sense = 1'b0;

    // Press key 5 straight after reset so the acceptance edge is 32.
    for (int i = 1; i <= 5; i++) add(0, 4'(i), 0, 0, 0, 0);
    add(1, 5, 0, 0, 0, 0);
    add(1, 5, 0, 0, 0, 0);
    add(1, 5, 5, 1, 1, 0);
    // Release with one bounce: 0,1,0,0,0.
    add(0, 5, 5, 0, 1, 0);
    add(1, 5, 5, 0, 1, 0);
    add(0, 5, 5, 0, 1, 0);
    add(0, 5, 5, 0, 1, 0);
    add(0, 6, 5, 0, 0, 1);
    // Idle sweep across the 15 -> 0 wrap.
    for (int i = 1; i <= 16; i++) add(0, 4'((6 + i) % 16), 5, 0, 0, 0);
    // Bounce abort on key 9.
    for (int i = 7; i <= 9; i++) add(0, 4'(i), 5, 0, 0, 0);
    add(1, 9, 5, 0, 0, 0);
    add(0, 10, 5, 0, 0, 0);
    // Key 15 press and release: resume at 0.
    for (int i = 11; i <= 15; i++) add(0, 4'(i), 5, 0, 0, 0);
    add(1, 15, 5, 0, 0, 0);
    add(1, 15, 5, 0, 0, 0);
    add(1, 15, 15, 1, 1, 0);
    add(0, 15, 15, 0, 1, 0);
    add(0, 15, 15, 0, 1, 0);
    add(0, 0, 15, 0, 0, 1);

    #12;
    chk("reset_state", {16'd0, scan_idx, key_code, 5'd0, key_valid, key_held, key_release}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);
    chk("press_edge", 32'(first_valid_cyc), 32'd32);

    // en pause inside CONFIRM on key 0.
    begin
      vec_t t;
      t.s = 1; t.idx = 0; t.code = 15; t.v = 0; t.h = 0; t.r = 0;
      run_vec(t, 100);
    end
    sense = 1'b1;
    repeat (2) @(posedge clk);
    #1; en = 1'b0; sense = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (scan_idx != 4'd0 || key_valid || key_release || key_held || key_code != 4'd15) bad = 1'b1;
    end
    chk("pause_frozen", 32'(bad), 32'd0);
    en = 1'b1; sense = 1'b1;
    repeat (SETTLE) @(posedge clk);
    #1;
    chk("resume_deb2", {30'd0, key_valid, key_held}, 32'd0);
    begin
      vec_t t;
      t.s = 1; t.idx = 0; t.code = 0; t.v = 1; t.h = 1; t.r = 0;
      run_vec(t, 101);
      t.s = 0; t.v = 0;
      run_vec(t, 102);
      run_vec(t, 103);
      t.idx = 1; t.h = 0; t.r = 1;
      run_vec(t, 104);
      t.r = 0;
      for (int i = 2; i <= 12; i++) begin
        t.idx = 4'(i);
        run_vec(t, 103 + i);
      end
      t.s = 1;
      run_vec(t, 116);
      run_vec(t, 117);
      t.code = 12; t.v = 1; t.h = 1;
      run_vec(t, 118);
    end

    // Async reset while key 12 is held.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {16'd0, scan_idx, key_code, 5'd0, key_valid, key_held, key_release}, 32'd0);
    sense = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    saw_rel = 1'b0;
    repeat (2 * SETTLE) begin
      @(posedge clk); #1;
      if (key_release) saw_rel = 1'b1;
    end
    chk("no_release_after_reset", 32'(saw_rel), 32'd0);
    chk("rescan_idx", 32'(scan_idx), 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
